// File: rtl/arm_mc_pkg.sv
// Shared definitions for the multicycle ARM control unit.
//   state_t      : FSM state encoding (TRAP is only reachable with MC_ILLEGAL_TRAP_EN)
//   ALU_*        : ALUControl codes
//   OP_*         : Instr[27:26] instruction classes
//   CMD_*        : data-processing cmd field values
//   RES_*        : ResultSrc encodings
//   SRCA_*/SRCB_*: ALU operand select encodings
//   COND_*       : condition codes with special meaning
package arm_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BRANCH,
      S_TRAP
   } state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_CMP = 4'b1010;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_RD1 = 2'b00;
   localparam logic [1:0] SRCA_PC  = 2'b01;

   localparam logic [1:0] SRCB_RD2    = 2'b00;
   localparam logic [1:0] SRCB_EXTIMM = 2'b01;
   localparam logic [1:0] SRCB_FOUR   = 2'b10;

   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/mc_controller_condcheck.sv
// ARM condition evaluation.
//   Cond   in  4  Instr[31:28]
//   Flags  in  4  {N,Z,C,V} registered flags
//   CondEx out 1  1 when the instruction should execute
// Cond=1111 evaluates false so an NV instruction can never write.
module condcheck
   import arm_mc_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v;
   assign {n, z, c, v} = Flags;

   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         4'b0000: CondEx = z;
         4'b0001: CondEx = ~z;
         4'b0010: CondEx = c;
         4'b0011: CondEx = ~c;
         4'b0100: CondEx = n;
         4'b0101: CondEx = ~n;
         4'b0110: CondEx = v;
         4'b0111: CondEx = ~v;
         4'b1000: CondEx = c & ~z;
         4'b1001: CondEx = ~c | z;
         4'b1010: CondEx = (n == v);
         4'b1011: CondEx = (n != v);
         4'b1100: CondEx = ~z & (n == v);
         4'b1101: CondEx = z | (n != v);
         COND_AL: CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: field decode, Moore sequencing FSM, NZCV flag register.
//   clk, reset (sync, active high)
//   Cond/Op/Funct/Rd : instruction fields from the IR
//   ALUFlags         : {N,Z,C,V} from the ALU this cycle
//   PCWrite/MemWrite/RegWrite/IRWrite : write strobes (forced 0 while reset=1)
//   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl : datapath selects
//   Illegal          : trap indicator
// Build option MC_ILLEGAL_TRAP_EN: illegal encodings park the FSM in TRAP (Illegal=1) until
// reset. Without it illegal encodings retire as a NOP and Illegal is tied 0.
//
// state    | meaning
// ---------+---------------------------------------------------------
// FETCH    | IR <= mem[PC], PC <= PC+4
// DECODE   | read registers, latch condition result
// MEMADR   | compute base + offset
// MEMRD    | read data memory
// MEMWB    | write loaded data to Rd
// MEMWR    | write data memory
// EXECUTER | ALU op with register operand, flags update
// EXECUTEI | ALU op with immediate operand, flags update
// ALUWB    | write ALU result to Rd
// BRANCH   | PC <= PC+8+offset
// TRAP     | illegal encoding seen, held until reset
module mc_controller
   import arm_mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] RegSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [1:0] ALUControl,
   output logic       Illegal
);

   state_t     state;
   logic [3:0] flags;
   logic       cond_ex_r;
   logic       cond_ex;

   logic [3:0] cmd;
   logic       s_bit, i_bit;
   logic [1:0] dp_alu;
   logic       cmd_known, is_cmp;
   logic       flag_w_nz, flag_w_cv;
   logic       illegal_enc;
   logic       pc_to_rd;

   condcheck u_condcheck (
      .Cond   (Cond),
      .Flags  (flags),
      .CondEx (cond_ex)
   );

   assign cmd      = Funct[4:1];
   assign s_bit    = Funct[0];
   assign i_bit    = Funct[5];
   assign pc_to_rd = (Rd == 4'hF);

   always_comb begin
      dp_alu    = ALU_ADD;
      cmd_known = 1'b1;
      flag_w_cv = 1'b0;
      case (cmd)
         CMD_ADD: begin dp_alu = ALU_ADD; flag_w_cv = s_bit; end
         CMD_SUB: begin dp_alu = ALU_SUB; flag_w_cv = s_bit; end
         CMD_CMP: begin dp_alu = ALU_SUB; flag_w_cv = s_bit; end
         CMD_AND: dp_alu = ALU_AND;
         CMD_ORR: dp_alu = ALU_ORR;
         default: cmd_known = 1'b0;
      endcase
   end

   assign is_cmp      = (cmd == CMD_CMP);
   assign flag_w_nz   = s_bit;
   // cmd checks only matter for data-processing; mem/branch reuse Funct differently.
   assign illegal_enc = (Cond == COND_NV) || (Op == 2'b11) ||
                        ((Op == OP_DP) && (!cmd_known || (is_cmp && !s_bit)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_FETCH;
         flags     <= 4'b0000;
         cond_ex_r <= 1'b0;
      end else begin
         case (state)
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               cond_ex_r <= cond_ex;
               if (illegal_enc) begin
`ifdef MC_ILLEGAL_TRAP_EN
                  state <= S_TRAP;
`else
                  state <= S_FETCH;
`endif
               end else begin
                  case (Op)
                     OP_MEM:  state <= S_MEMADR;
                     OP_BR:   state <= S_BRANCH;
                     default: state <= i_bit ? S_EXECUTEI : S_EXECUTER;
                  endcase
               end
            end
            S_MEMADR: state <= s_bit ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state <= S_MEMWB;
            S_EXECUTER, S_EXECUTEI: begin
               if (cond_ex_r) begin
                  if (flag_w_nz) flags[3:2] <= ALUFlags[3:2];
                  if (flag_w_cv) flags[1:0] <= ALUFlags[1:0];
               end
               state <= is_cmp ? S_FETCH : S_ALUWB;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:   state <= S_TRAP;
`endif
            default:  state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = SRCA_RD1;
      ALUSrcB    = SRCB_RD2;
      ResultSrc  = RES_ALUOUT;
      ALUControl = ALU_ADD;
      Illegal    = 1'b0;
      case (state)
         S_FETCH: begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         S_DECODE: begin
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         S_MEMADR: ALUSrcB = SRCB_EXTIMM;
         S_MEMRD:  AdrSrc  = 1'b1;
         S_MEMWR: begin
            AdrSrc   = 1'b1;
            MemWrite = cond_ex_r;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = cond_ex_r;
            PCWrite   = cond_ex_r & pc_to_rd;
         end
         S_EXECUTER: ALUControl = dp_alu;
         S_EXECUTEI: begin
            ALUSrcB    = SRCB_EXTIMM;
            ALUControl = dp_alu;
         end
         S_ALUWB: begin
            RegWrite = cond_ex_r;
            PCWrite  = cond_ex_r & pc_to_rd;
         end
         S_BRANCH: begin
            ALUSrcB   = SRCB_EXTIMM;
            ResultSrc = RES_ALURESULT;
            PCWrite   = cond_ex_r;
         end
`ifdef MC_ILLEGAL_TRAP_EN
         S_TRAP: Illegal = 1'b1;
`endif
         default: ;
      endcase
      // Reset must suppress every write even though state still shows the aborted step.
      if (reset) begin
         PCWrite  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
         IRWrite  = 1'b0;
         Illegal  = 1'b0;
      end
   end

   assign RegSrc = {(Op == OP_MEM) & ~s_bit, (Op == OP_BR)};
   assign ImmSrc = Op;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller. Strobe checks use {PCWrite,MemWrite,RegWrite,IRWrite}.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, Illegal;
   logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

   int checks   = 0;
   int failures = 0;

   mc_controller dut (
      .clk        (clk),
      .reset      (reset),
      .Cond       (Cond),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .IRWrite    (IRWrite),
      .AdrSrc     (AdrSrc),
      .RegSrc     (RegSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .Illegal    (Illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_strb(input string tag, input logic [3:0] exp);
      chk(tag, 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'(exp));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called while in FETCH; leaves the FSM in DECODE.
   task automatic fetch_decode(input logic [3:0] c, input logic [1:0] o,
                               input logic [5:0] f, input logic [3:0] r);
      Cond  = c;
      Op    = o;
      Funct = f;
      Rd    = r;
      tick();
   endtask

   initial begin
      reset    = 1'b1;
      Cond     = 4'hE;
      Op       = 2'b00;
      Funct    = 6'b001000;
      Rd       = 4'h0;
      ALUFlags = 4'h0;
      tick();
      tick();
      chk_strb("rst_strb", 4'b0000);
      chk("rst_illegal", 32'(Illegal), 0);
      reset = 1'b0;
      #1;
      chk_strb("fetch0_strb", 4'b1001);
      chk("fetch0_srca", 32'(ALUSrcA), 1);
      chk("fetch0_srcb", 32'(ALUSrcB), 2);
      chk("fetch0_res", 32'(ResultSrc), 2);
      chk("fetch0_alu", 32'(ALUControl), 0);
      chk("fetch0_adr", 32'(AdrSrc), 0);
      chk("fetch0_flags", 32'(dut.flags), 0);

      // ADDS R1,R2,R3
      ALUFlags = 4'b0100;
      fetch_decode(4'hE, 2'b00, 6'b001001, 4'h1);
      chk_strb("adds_dec_strb", 4'b0000);
      chk("adds_dec_srcb", 32'(ALUSrcB), 2);
      tick();
      chk_strb("adds_exe_strb", 4'b0000);
      chk("adds_exe_srca", 32'(ALUSrcA), 0);
      chk("adds_exe_srcb", 32'(ALUSrcB), 0);
      chk("adds_exe_alu", 32'(ALUControl), 0);
      tick();
      chk_strb("adds_wb_strb", 4'b0010);
      chk("adds_wb_res", 32'(ResultSrc), 0);
      chk("adds_flags", 32'(dut.flags), 4'b0100);
      tick();
      chk_strb("adds_fetch", 4'b1001);

      // CMP with Z=1, then BEQ taken
      ALUFlags = 4'b0100;
      fetch_decode(4'hE, 2'b00, 6'b010101, 4'h0);
      tick();
      chk("cmp_alu", 32'(ALUControl), 1);
      tick();
      chk_strb("cmp_3cyc_fetch", 4'b1001);
      chk("cmp_flags", 32'(dut.flags), 4'b0100);
      fetch_decode(4'h0, 2'b10, 6'b000000, 4'h0);
      tick();
      chk_strb("beq_taken", 4'b1000);
      chk("beq_srca", 32'(ALUSrcA), 0);
      chk("beq_srcb", 32'(ALUSrcB), 1);
      chk("beq_res", 32'(ResultSrc), 2);
      chk("beq_regsrc", 32'(RegSrc), 1);
      tick();
      chk_strb("beq_fetch", 4'b1001);

      // CMP with Z=0, BEQ not taken
      ALUFlags = 4'b0000;
      fetch_decode(4'hE, 2'b00, 6'b010101, 4'h0);
      tick();
      tick();
      chk("cmp0_flags", 32'(dut.flags), 0);
      fetch_decode(4'h0, 2'b10, 6'b000000, 4'h0);
      tick();
      chk_strb("beq_not_taken", 4'b0000);
      tick();

      // LDR R5
      fetch_decode(4'hE, 2'b01, 6'b000001, 4'h5);
      chk("ldr_immsrc", 32'(ImmSrc), 1);
      tick();
      chk_strb("ldr_adr_strb", 4'b0000);
      chk("ldr_adr_srca", 32'(ALUSrcA), 0);
      chk("ldr_adr_srcb", 32'(ALUSrcB), 1);
      chk("ldr_adr_alu", 32'(ALUControl), 0);
      tick();
      chk("ldr_rd_adrsrc", 32'(AdrSrc), 1);
      chk_strb("ldr_rd_strb", 4'b0000);
      tick();
      chk_strb("ldr_wb_strb", 4'b0010);
      chk("ldr_wb_res", 32'(ResultSrc), 1);
      tick();
      chk_strb("ldr_5cyc_fetch", 4'b1001);

      // LDR PC
      fetch_decode(4'hE, 2'b01, 6'b000001, 4'hF);
      tick();
      tick();
      tick();
      chk_strb("ldr_pc_wb_strb", 4'b1010);
      tick();

      // Z=1 then STRNE (suppressed) and STR AL
      ALUFlags = 4'b0100;
      fetch_decode(4'hE, 2'b00, 6'b010101, 4'h0);
      tick();
      tick();
      fetch_decode(4'h1, 2'b01, 6'b000000, 4'h2);
      tick();
      chk("strne_adr_regsrc", 32'(RegSrc), 2);
      tick();
      chk_strb("strne_wr_strb", 4'b0000);
      chk("strne_wr_adrsrc", 32'(AdrSrc), 1);
      chk("strne_wr_regsrc", 32'(RegSrc), 2);
      tick();
      chk_strb("strne_fetch", 4'b1001);
      fetch_decode(4'hE, 2'b01, 6'b000000, 4'h2);
      tick();
      tick();
      chk_strb("str_wr_strb", 4'b0100);
      tick();

      // SUBSNE with Z=1: nothing written
      ALUFlags = 4'b1111;
      fetch_decode(4'h1, 2'b00, 6'b000101, 4'h3);
      tick();
      chk("subsne_alu", 32'(ALUControl), 1);
      tick();
      chk_strb("subsne_wb_strb", 4'b0000);
      chk("subsne_flags", 32'(dut.flags), 4'b0100);
      tick();

      // ANDS: only NZ update, CV kept
      ALUFlags = 4'b1011;
      fetch_decode(4'hE, 2'b00, 6'b000001, 4'h3);
      tick();
      chk("ands_alu", 32'(ALUControl), 2);
      tick();
      chk_strb("ands_wb_strb", 4'b0010);
      chk("ands_flags", 32'(dut.flags), 4'b1000);
      tick();

      // ORR immediate without S
      ALUFlags = 4'b0111;
      fetch_decode(4'hE, 2'b00, 6'b111000, 4'h4);
      tick();
      chk("orri_srca", 32'(ALUSrcA), 0);
      chk("orri_srcb", 32'(ALUSrcB), 1);
      chk("orri_alu", 32'(ALUControl), 3);
      tick();
      chk_strb("orri_wb_strb", 4'b0010);
      chk("orri_flags", 32'(dut.flags), 4'b1000);
      tick();

      // Reset during EXECUTER: no flag write, strobes off
      ALUFlags = 4'b1111;
      fetch_decode(4'hE, 2'b00, 6'b001001, 4'h1);
      tick();
      reset = 1'b1;
      tick();
      chk_strb("rst_mid_strb", 4'b0000);
      chk("rst_mid_flags", 32'(dut.flags), 0);
      reset = 1'b0;
      #1;
      chk_strb("rst_mid_fetch", 4'b1001);

`ifdef MC_ILLEGAL_TRAP_EN
      fetch_decode(4'hE, 2'b11, 6'b000000, 4'h0);
      chk("op11_dec_illegal", 32'(Illegal), 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("trap_illegal", 32'(Illegal), 1);
         chk_strb("trap_strb", 4'b0000);
      end
      reset = 1'b1;
      tick();
      chk("trap_rst_illegal", 32'(Illegal), 0);
      reset = 1'b0;
      #1;
      chk_strb("trap_rst_fetch", 4'b1001);
`else
      fetch_decode(4'hE, 2'b11, 6'b000000, 4'h0);
      chk_strb("op11_dec_strb", 4'b0000);
      tick();
      chk_strb("op11_nop_fetch", 4'b1001);
      chk("op11_illegal", 32'(Illegal), 0);
      fetch_decode(4'hF, 2'b00, 6'b001000, 4'h1);
      tick();
      chk_strb("nv_nop_fetch", 4'b1001);
      fetch_decode(4'hE, 2'b00, 6'b010100, 4'h0);
      tick();
      chk_strb("cmp_nos_nop_fetch", 4'b1001);
      fetch_decode(4'hE, 2'b00, 6'b011110, 4'h1);
      tick();
      chk_strb("badcmd_nop_fetch", 4'b1001);
      chk("nop_illegal", 32'(Illegal), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
